// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV64I instruction encoder.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_LI32 = 3'd5
  } fmt_e;

  typedef enum logic {
    IDLE  = 1'b0,
    EMIT2 = 1'b1
  } enc_state_e;

  localparam logic [6:0]  OP_IMM   = 7'h13;
  localparam logic [6:0]  OP_IMM32 = 7'h1B;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // True when v[63:msb] is a pure sign extension, i.e. v fits in msb+1 signed bits.
  function automatic logic sext_ok(input logic [63:0] v, input int unsigned msb);
    logic [63:0] t;
    t = 64'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packing and immediate range checks; zero latency.
// No state and no handshake: the caller samples the result on its accept edge.
module instr_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_beat,
  output logic        err
);

  logic [11:0] lo;
  logic [19:0] hi;

  // (imm + 0x800) >> 12 on 32 bits: the rounding carry into bit 12 is just imm[11].
  assign lo = imm[11:0];
  assign hi = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    word0    = NOP;
    word1    = NOP;
    two_beat = 1'b0;
    err      = 1'b0;
    case (fmt_e'(fmt))
      FMT_I: begin
        err   = !sext_ok(imm, 11);
        word0 = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        err   = !sext_ok(imm, 11);
        word0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        err   = !sext_ok(imm, 12) || imm[0];
        word0 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        err   = (imm[11:0] != 12'd0) || !sext_ok(imm, 31);
        word0 = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        err   = !sext_ok(imm, 20) || imm[0];
        word0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_LI32: begin
        err = !sext_ok(imm, 31);
        if (hi == 20'd0) begin
          word0 = {lo, 5'd0, 3'd0, rd, OP_IMM};
        end else if (lo == 12'd0) begin
          word0 = {hi, rd, OP_LUI};
        end else begin
          word0    = {hi, rd, OP_LUI};
          word1    = {lo, rd, 3'd0, rd, OP_IMM32};
          two_beat = 1'b1;
        end
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      word0    = NOP;
      word1    = NOP;
      two_beat = 1'b0;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV64I requests into 32-bit words (LI32 expands to one or two words); 1-cycle registered latency.
// Backpressure: req_ready drops while the output word is stalled or a second LI32 word is pending.
module instr_encoder
  import rv_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [63:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  enc_state_e  state;
  enc_state_e  state_nxt;
  logic        accept;
  logic        load2;
  logic [31:0] pk_word0;
  logic [31:0] pk_word1;
  logic        pk_two;
  logic        pk_err;
  logic [31:0] pend_instr;

  instr_pack u_pack (
    .fmt      (req_fmt),
    .opcode   (req_opcode),
    .funct3   (req_funct3),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .word0    (pk_word0),
    .word1    (pk_word1),
    .two_beat (pk_two),
    .err      (pk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && pk_two) state_nxt = EMIT2;
      EMIT2:   if (load2)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In EMIT2 the output register always holds the first LI32 word, so out_ready alone frees it.
  always_comb begin
    req_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    accept    = req_valid && req_ready;
    load2     = rst_n && (state == EMIT2) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= pk_word0;
      out_err   <= pk_err;
      out_last  <= !pk_two;
    end else if (load2) begin
      out_valid <= 1'b1;
      out_instr <= pend_instr;
      out_err   <= 1'b0;
      out_last  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_instr <= pk_word1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected beats queued at drive time, popped as the DUT emits them.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [63:0] imm;
    logic        two;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } li_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [63:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t sb[$];

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Drive one request from a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [63:0] imm, output bit ok);
    req_fmt = fmt; req_opcode = op; req_funct3 = f3;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Observe the next output beat (out_ready must be high); returns one negedge after it is consumed.
  task automatic get_beat(output beat_t obs, output bit ok);
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        obs = {out_instr, out_err, out_last};
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_fmt = '0; req_opcode = '0; req_funct3 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_err, out_last} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: valid/err/last=%b want 000", {out_valid, out_err, out_last});
    end
    n_tests++;
    if (out_instr !== 32'd0) begin
      n_fail++; $display("FAIL reset_instr: got %h want 00000000", out_instr);
    end
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_fields();
    vec_t  v[22];
    beat_t obs, exp_b;
    bit    ok;
    v[0]  = '{FMT_I, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -64'sd1,        32'hFFF30293, 1'b0};
    v[1]  = '{FMT_I, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'sd2047,      32'h7FF30293, 1'b0};
    v[2]  = '{FMT_I, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, -64'sd2048,     32'h80030293, 1'b0};
    v[3]  = '{FMT_I, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'sd2048,      32'h00000013, 1'b1};
    v[4]  = '{FMT_S, 7'h23, 3'd3, 5'd0, 5'd2, 5'd8, -64'sd8,        32'hFE813C23, 1'b0};
    v[5]  = '{FMT_S, 7'h23, 3'd3, 5'd0, 5'd2, 5'd8, -64'sd2049,     32'h00000013, 1'b1};
    v[6]  = '{FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'sd8,         32'h00208463, 1'b0};
    v[7]  = '{FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'sd7,         32'h00000013, 1'b1};
    v[8]  = '{FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'sd4094,      32'h7E208FE3, 1'b0};
    v[9]  = '{FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4096,     32'h80208063, 1'b0};
    v[10] = '{FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'sd4096,      32'h00000013, 1'b1};
    v[11] = '{FMT_U, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 64'h12345000,   32'h123450B7, 1'b0};
    v[12] = '{FMT_U, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, -64'sd4096,     32'hFFFFF0B7, 1'b0};
    v[13] = '{FMT_U, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 64'h12345001,   32'h00000013, 1'b1};
    v[14] = '{FMT_U, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 64'h80000000,   32'h00000013, 1'b1};
    v[15] = '{FMT_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'sd2048,      32'h001000EF, 1'b0};
    v[16] = '{FMT_J, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'sd1048574,   32'h7FFFF06F, 1'b0};
    v[17] = '{FMT_J, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd1048576,  32'h8000006F, 1'b0};
    v[18] = '{FMT_J, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'sd1048576,   32'h00000013, 1'b1};
    v[19] = '{FMT_J, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'sd3,         32'h00000013, 1'b1};
    v[20] = '{3'd6,  7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'sd0,         32'h00000013, 1'b1};
    v[21] = '{3'd7,  7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'sd0,         32'h00000013, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      sb.push_back('{v[k].instr, v[k].err, 1'b1});
      send(v[k].fmt, v[k].op, v[k].f3, v[k].rd, v[k].rs1, v[k].rs2, v[k].imm, ok);
      n_tests++;
      if (!ok || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL fields_latency[%0d]: accepted=%0b out_valid=%b want 1", k, ok, out_valid);
      end
      get_beat(obs, ok);
      exp_b = sb.pop_front();
      n_tests++;
      if (!ok || obs !== exp_b) begin
        n_fail++;
        $display("FAIL fields[%0d]: got %h err=%b last=%b (seen=%0b) want %h err=%b last=%b",
                 k, obs.instr, obs.err, obs.last, ok, exp_b.instr, exp_b.err, exp_b.last);
      end
    end
  endtask

  task automatic test_li32();
    li_t   t[8];
    beat_t obs, exp_b;
    bit    ok;
    t[0] = '{64'h12345FFF,           1'b1, 32'h12346537, 32'hFFF5051B, 1'b0};
    t[1] = '{-64'sd5,                1'b0, 32'hFFB00513, 32'h0,        1'b0};
    t[2] = '{64'h1_0000_0000,        1'b0, 32'h00000013, 32'h0,        1'b1};
    t[3] = '{64'h12345000,           1'b0, 32'h12345537, 32'h0,        1'b0};
    t[4] = '{64'h7FFFF800,           1'b1, 32'h80000537, 32'h8005051B, 1'b0};
    t[5] = '{64'hFFFFFFFF80000000,   1'b0, 32'h80000537, 32'h0,        1'b0};
    t[6] = '{-64'sd2048,             1'b0, 32'h80000513, 32'h0,        1'b0};
    t[7] = '{64'sd0,                 1'b0, 32'h00000513, 32'h0,        1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{t[k].w0, t[k].err, !t[k].two});
      if (t[k].two) sb.push_back('{t[k].w1, 1'b0, 1'b1});
      send(FMT_LI32, 7'h55, 3'd5, 5'd10, 5'd3, 5'd4, t[k].imm, ok);
      if (t[k].two) begin
        n_tests++;
        if (!ok || req_ready !== 1'b0) begin
          n_fail++; $display("FAIL li32_ready_between[%0d]: req_ready=%b want 0", k, req_ready);
        end
      end
      for (int b = 0; b < (t[k].two ? 2 : 1); b++) begin
        get_beat(obs, ok);
        exp_b = sb.pop_front();
        n_tests++;
        if (!ok || obs !== exp_b) begin
          n_fail++;
          $display("FAIL li32[%0d] beat%0d: got %h err=%b last=%b (seen=%0b) want %h err=%b last=%b",
                   k, b, obs.instr, obs.err, obs.last, ok, exp_b.instr, exp_b.err, exp_b.last);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t obs, exp_b;
    bit    ok;
    sb.push_back('{32'h12346537, 1'b0, 1'b0});
    sb.push_back('{32'hFFF5051B, 1'b0, 1'b1});
    sb.push_back('{32'h00100093, 1'b0, 1'b1});
    out_ready = 1'b0;
    send(FMT_LI32, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h12345FFF, ok);
    // Pending addi x1,x0,1 must wait until the LI32 pair has fully drained.
    req_fmt = FMT_I; req_opcode = 7'h13; req_funct3 = 3'd0;
    req_rd = 5'd1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 64'sd1;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (!ok || out_valid !== 1'b1 || {out_instr, out_err, out_last} !== sb[0]) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b got %h err=%b last=%b want %h err=0 last=0",
                           c, out_valid, out_instr, out_err, out_last, sb[0].instr);
      end
      n_tests++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", c, req_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      get_beat(obs, ok);
      if (b == 1) req_valid = 1'b0;
      exp_b = sb.pop_front();
      n_tests++;
      if (!ok || obs !== exp_b) begin
        n_fail++;
        $display("FAIL bp_seq beat%0d: got %h err=%b last=%b (seen=%0b) want %h err=%b last=%b",
                 b, obs.instr, obs.err, obs.last, ok, exp_b.instr, exp_b.err, exp_b.last);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t obs, exp_b;
    bit    ok;
    bit    leaked;
    out_ready = 1'b1;
    sb.push_back('{32'h12346537, 1'b0, 1'b0});
    send(FMT_LI32, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h12345FFF, ok);
    get_beat(obs, ok);
    exp_b = sb.pop_front();
    n_tests++;
    if (!ok || obs !== exp_b) begin
      n_fail++; $display("FAIL rstmid_first: got %h last=%b (seen=%0b) want %h last=0", obs.instr, obs.last, ok, exp_b.instr);
    end
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_clear: out_valid=%b req_ready=%b want 0 0", out_valid, req_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    leaked = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_instr === 32'hFFF5051B) leaked = 1'b1;
    end
    n_tests++;
    if (leaked) begin
      n_fail++; $display("FAIL rstmid_no_second: second beat or stray output seen after reset, want none");
    end
    sb.push_back('{32'h00100093, 1'b0, 1'b1});
    send(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'sd1, ok);
    get_beat(obs, ok);
    exp_b = sb.pop_front();
    n_tests++;
    if (!ok || obs !== exp_b) begin
      n_fail++; $display("FAIL rstmid_after: got %h err=%b last=%b (seen=%0b) want %h err=0 last=1",
                         obs.instr, obs.err, obs.last, ok, exp_b.instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] r;
    logic [4:0]  rd, rs1;
    logic [2:0]  f3;
    beat_t       exp_b;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      r = 12'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); f3 = 3'($urandom);
      req_fmt = FMT_I; req_opcode = 7'h13; req_funct3 = f3;
      req_rd = rd; req_rs1 = rs1; req_rs2 = 5'($urandom); req_imm = {{52{r[11]}}, r};
      req_valid = 1'b1;
      sb.push_back('{{r, rs1, f3, rd, 7'h13}, 1'b0, 1'b1});
      n_tests++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      exp_b = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_instr, out_err, out_last} !== exp_b) begin
        n_fail++; $display("FAIL b2b[%0d]: valid=%b got %h err=%b last=%b want %h err=0 last=1",
                           k, out_valid, out_instr, out_err, out_last, exp_b.instr);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fields();
    test_li32();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 req_valid  in  1  encode request present.
REQ-004 req_ready  out  1  request accepted on edge where req_valid && req_ready.
REQ-005 req_fmt  in  3  format: FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI32; other codes illegal.
REQ-006 req_opcode  in  7  opcode for I/S/B/U/J; ignored for LI32.
REQ-007 req_funct3  in  3  funct3 for I/S/B; ignored otherwise.
REQ-008 req_rd, req_rs1, req_rs2  in  5 each  register fields; unused fields ignored.
REQ-009 req_imm  in  64  signed immediate, byte offset for B/J, full value (low 12 bits zero) for U.
REQ-010 out_valid  out  1  output word present.
REQ-011 out_ready  in  1  consumer accepts on edge where out_valid && out_ready.
REQ-012 out_instr  out  32  encoded instruction word.
REQ-013 out_err  out  1  request rejected; out_instr = NOP 32'h0000_0013.
REQ-014 out_last  out  1  final word of current request.

Function
REQ-015 Field packing SHALL be the exact RV64I inverse of immediate extraction: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5|4:1|11]->[31|30:25|11:8|7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12].
REQ-016 Range checks, failure -> out_err=1: I/S -2048..2047; B -4096..4094 and even; J -2^20..2^20-2 and even; U imm[11:0]==0 and imm[63:31] all equal; LI32 imm[63:31] all equal; illegal req_fmt always errors.
REQ-017 Error response SHALL be one beat, out_err=1, out_last=1, out_instr=NOP.
REQ-018 LI32: lo=imm[11:0]; hi=(imm[31:0]+32'h800)[31:12], 32-bit wrap.
REQ-019 LI32 hi==0: one beat ADDI rd,x0,lo (opcode 0x13, funct3 0).
REQ-020 LI32 hi!=0, lo==0: one beat LUI rd,hi (opcode 0x37).
REQ-021 LI32 hi!=0, lo!=0: two beats LUI rd,hi (out_last=0), then ADDIW rd,rd,lo (opcode 0x1B, funct3 0, out_last=1).
REQ-022 FSM states IDLE, EMIT2; IDLE->EMIT2 on accept of two-beat LI32 once its first beat issues; EMIT2->IDLE when second beat loads into output register.
REQ-023 Output is one registered stage: accepted request at edge N -> out_valid at cycle N+1; second LI32 beat loads on the edge the first beat is consumed.
REQ-024 req_ready = (state==IDLE) && (!out_valid || out_ready); full throughput of one word per cycle with no bubble.
REQ-025 While out_valid && !out_ready, out_instr/out_err/out_last SHALL hold stable.
REQ-026 Request fields are sampled only at accept; later input changes have no effect.

Reset
REQ-027 rst_n low at an edge: out_valid=0, out_instr=0, out_err=0, out_last=0, state=IDLE, req_ready=0 that cycle.
REQ-028 Reset mid-LI32 SHALL discard the pending second beat; it is never emitted.

Structure
REQ-029 Package rv_enc_pkg SHALL hold the fmt enum, opcode constants (OP_IMM 0x13, OP_IMM32 0x1B, LUI 0x37) and NOP constant.
REQ-030 Combinational sub-module instr_pack SHALL do field packing and range checks; instr_encoder owns handshake, FSM and output register.

Verification
REQ-031 FMT_I opcode 0x13 funct3 0 rd=5 rs1=6 imm=-1 -> 0xFFF30293, out_last=1, one cycle after accept.
REQ-032 FMT_B opcode 0x63 funct3 0 rs1=1 rs2=2 imm=8 -> 0x00208463; same with imm=7 -> out_err=1, 0x00000013.
REQ-033 FMT_LI32 rd=10 imm=0x12345FFF -> 0x12346537 (last=0), then 0xFFF5051B (last=1); req_ready low between.
REQ-034 FMT_LI32 rd=10 imm=-5 -> single 0xFFB00513, last=1; imm=0x1_0000_0000 -> out_err=1.
REQ-035 out_ready low 3 cycles during 0x12345FFF LI32 -> 0x12346537 held stable, no new request accepted, then sequence completes.
REQ-036 rst_n low one cycle after 0x12346537 is consumed -> out_valid=0 next cycle, 0xFFF5051B never appears, next request encoded normally.
